// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin share of one data-RAM port between core (M0) and loader (M1).
// Latency: grant and RAM strobes combinational; read data returned RD_LAT (1..4) cycles after grant.
// Backpressure: losers see gnt=0 and hold; core also gets o_core_stall. ARB_STALL_CNT_EN adds a stall counter.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_m0_req,
  input  logic                  i_m0_we,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_wdata,
  output logic                  o_m0_gnt,
  output logic                  o_m0_rvalid,
  output logic [DATA_WIDTH-1:0] o_m0_rdata,
  input  logic                  i_m1_req,
  input  logic                  i_m1_we,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_wdata,
  output logic                  o_m1_gnt,
  output logic                  o_m1_rvalid,
  output logic [DATA_WIDTH-1:0] o_m1_rdata,
  output logic                  o_ram_we,
  output logic                  o_ram_re,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wd,
  input  logic [DATA_WIDTH-1:0] i_ram_rd,
  output logic                  o_core_stall,
  output logic [31:0]           o_stall_cnt
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  state_t                state_q, state_d;
  logic [2:0]            lat_q, lat_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;

  logic                  rd_done, arb_free, gnt0, gnt1, any_gnt;
  logic                  rv0, rv1, win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wd;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      owner_q    <= OWN_M0;
      last_q     <= OWN_M1;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      if (rv0) m0_rdata_q <= i_ram_rd;
      if (rv1) m1_rdata_q <= i_ram_rd;
    end
  end

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    owner_d  = owner_q;
    last_d   = last_q;
    rd_done  = 1'b0;
    arb_free = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;

    case (state_q)
      IDLE: arb_free = 1'b1;
      RD_WAIT: begin
        lat_d = lat_q - 3'd1;
        // Final wait cycle: data returns and the port is free for a back-to-back grant.
        if (lat_q == 3'd1) begin
          rd_done  = 1'b1;
          arb_free = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every combinational output is forced low while reset is asserted.
    if (arb_free && !i_rst) begin
      gnt0 = i_m0_req && (!i_m1_req || last_q == OWN_M1);
      gnt1 = i_m1_req && (!i_m0_req || last_q == OWN_M0);
    end
    any_gnt = gnt0 || gnt1;

    win_we   = gnt1 ? i_m1_we    : i_m0_we;
    win_addr = gnt1 ? i_m1_addr  : i_m0_addr;
    win_wd   = gnt1 ? i_m1_wdata : i_m0_wdata;

    if (any_gnt) begin
      last_d = gnt1;
      if (!win_we) begin
        state_d = RD_WAIT;
        lat_d   = 3'(RD_LAT);
        owner_d = gnt1;
      end
    end

    rv0 = !i_rst && rd_done && owner_q == OWN_M0;
    rv1 = !i_rst && rd_done && owner_q == OWN_M1;

    o_m0_gnt     = gnt0;
    o_m1_gnt     = gnt1;
    o_ram_we     = any_gnt && win_we;
    o_ram_re     = any_gnt && !win_we;
    o_ram_addr   = any_gnt ? win_addr : '0;
    o_ram_wd     = any_gnt ? win_wd   : '0;
    o_m0_rvalid  = rv0;
    o_m1_rvalid  = rv1;
    o_m0_rdata   = i_rst ? '0 : (rv0 ? i_ram_rd : m0_rdata_q);
    o_m1_rdata   = i_rst ? '0 : (rv1 ? i_ram_rd : m1_rdata_q);
    o_core_stall = !i_rst && i_m0_req && !gnt0;
  end

`ifdef ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
    end else if (o_core_stall && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt = i_rst ? 32'h0 : stall_cnt_q;
`else
  assign o_stall_cnt = 32'h0;
`endif

  // A refused requester must hold its request unchanged until granted.
  m0_hold_chk: assert property (@(posedge i_clk) disable iff (i_rst)
    (i_m0_req && !o_m0_gnt) |=> (i_m0_req && $stable(i_m0_we) && $stable(i_m0_addr) && $stable(i_m0_wdata)));
  m1_hold_chk: assert property (@(posedge i_clk) disable iff (i_rst)
    (i_m1_req && !o_m1_gnt) |=> (i_m1_req && $stable(i_m1_we) && $stable(i_m1_addr) && $stable(i_m1_wdata)));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: three instances (RD_LAT = 1, 2, 3), each with its own RAM model.
module tb_ram_port_arbiter;

  typedef struct packed {
    logic        rst;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
  } in_t;

  typedef struct packed {
    logic        m0_gnt;
    logic        m1_gnt;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_addr;
    logic [31:0] ram_wd;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic        core_stall;
  } obs_t;

  typedef struct {
    in_t  in;
    obs_t exp;
  } vec_t;

`ifdef ARB_STALL_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t         din        [3];
  logic        m0_gnt     [3];
  logic        m0_rvalid  [3];
  logic [31:0] m0_rdata   [3];
  logic        m1_gnt     [3];
  logic        m1_rvalid  [3];
  logic [31:0] m1_rdata   [3];
  logic        ram_we     [3];
  logic        ram_re     [3];
  logic [31:0] ram_addr   [3];
  logic [31:0] ram_wd     [3];
  logic [31:0] ram_rd     [3];
  logic        core_stall [3];
  logic [31:0] stall_cnt  [3];

  int n_checks = 0;
  int n_pass   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LAT(g + 1)) u_dut (
      .i_clk       (clk),
      .i_rst       (din[g].rst),
      .i_m0_req    (din[g].m0_req),
      .i_m0_we     (din[g].m0_we),
      .i_m0_addr   (din[g].m0_addr),
      .i_m0_wdata  (din[g].m0_wdata),
      .o_m0_gnt    (m0_gnt[g]),
      .o_m0_rvalid (m0_rvalid[g]),
      .o_m0_rdata  (m0_rdata[g]),
      .i_m1_req    (din[g].m1_req),
      .i_m1_we     (din[g].m1_we),
      .i_m1_addr   (din[g].m1_addr),
      .i_m1_wdata  (din[g].m1_wdata),
      .o_m1_gnt    (m1_gnt[g]),
      .o_m1_rvalid (m1_rvalid[g]),
      .o_m1_rdata  (m1_rdata[g]),
      .o_ram_we    (ram_we[g]),
      .o_ram_re    (ram_re[g]),
      .o_ram_addr  (ram_addr[g]),
      .o_ram_wd    (ram_wd[g]),
      .i_ram_rd    (ram_rd[g]),
      .o_core_stall(core_stall[g]),
      .o_stall_cnt (stall_cnt[g])
    );

    // RAM model: data of a read strobed at cycle t appears on ram_rd at t+RD_LAT.
    logic [31:0] mem  [16];
    logic [31:0] pipe [4];
    always @(posedge clk) begin
      if (ram_we[g]) mem[ram_addr[g][5:2]] <= ram_wd[g];
      pipe[0] <= ram_re[g] ? mem[ram_addr[g][5:2]] : 32'hBAD0_BAD0;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign ram_rd[g] = pipe[g];
  end

  function automatic in_t mk_in(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                                input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    in_t v;
    v.rst = 1'b0;
    v.m0_req = r0; v.m0_we = w0; v.m0_addr = a0; v.m0_wdata = d0;
    v.m1_req = r1; v.m1_we = w1; v.m1_addr = a1; v.m1_wdata = d1;
    return v;
  endfunction

  function automatic obs_t mk_exp(input logic g0, input logic g1, input logic we, input logic re,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic rv0, input logic [31:0] rd0,
                                  input logic rv1, input logic [31:0] rd1, input logic st);
    obs_t o;
    o.m0_gnt = g0; o.m1_gnt = g1; o.ram_we = we; o.ram_re = re;
    o.ram_addr = addr; o.ram_wd = wd;
    o.m0_rvalid = rv0; o.m0_rdata = rd0;
    o.m1_rvalid = rv1; o.m1_rdata = rd1;
    o.core_stall = st;
    return o;
  endfunction

  function automatic obs_t get_obs(input int g);
    obs_t o;
    o.m0_gnt = m0_gnt[g]; o.m1_gnt = m1_gnt[g]; o.ram_we = ram_we[g]; o.ram_re = ram_re[g];
    o.ram_addr = ram_addr[g]; o.ram_wd = ram_wd[g];
    o.m0_rvalid = m0_rvalid[g]; o.m0_rdata = m0_rdata[g];
    o.m1_rvalid = m1_rvalid[g]; o.m1_rdata = m1_rdata[g];
    o.core_stall = core_stall[g];
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("gnt=%b%b we=%b re=%b addr=%h wd=%h rv0=%b rd0=%h rv1=%b rd1=%h stall=%b",
                     o.m0_gnt, o.m1_gnt, o.ram_we, o.ram_re, o.ram_addr, o.ram_wd,
                     o.m0_rvalid, o.m0_rdata, o.m1_rvalid, o.m1_rdata, o.core_stall);
  endfunction

  task automatic check_obs(input int g, input obs_t exp, input string name);
    obs_t act;
    act = get_obs(g);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (dut%0d): got {%s} expected {%s}", name, g, fmt(act), fmt(exp));
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vec [13];

  initial begin
    int   k0, k1;
    logic e0, e1;

    // Directed vectors for the RD_LAT=1 instance, one per cycle, starting right after reset.
    vec[0]  = '{mk_in(0,0,0,0, 0,0,0,0),
                mk_exp(0,0,0,0, 32'h0,  32'h0,        0,32'h0,        0,32'h0,        0)};
    vec[1]  = '{mk_in(1,1,32'h10,32'hDEADBEEF, 0,0,0,0),
                mk_exp(1,0,1,0, 32'h10, 32'hDEADBEEF, 0,32'h0,        0,32'h0,        0)};
    vec[2]  = '{mk_in(1,0,32'h10,0, 0,0,0,0),
                mk_exp(1,0,0,1, 32'h10, 32'h0,        0,32'h0,        0,32'h0,        0)};
    vec[3]  = '{mk_in(0,0,0,0, 0,0,0,0),
                mk_exp(0,0,0,0, 32'h0,  32'h0,        1,32'hDEADBEEF, 0,32'h0,        0)};
    vec[4]  = '{mk_in(0,0,0,0, 0,0,0,0),
                mk_exp(0,0,0,0, 32'h0,  32'h0,        0,32'hDEADBEEF, 0,32'h0,        0)};
    vec[5]  = '{mk_in(0,0,0,0, 1,1,32'h20,32'h12345678),
                mk_exp(0,1,1,0, 32'h20, 32'h12345678, 0,32'hDEADBEEF, 0,32'h0,        0)};
    vec[6]  = '{mk_in(1,1,32'h24,32'hA, 1,1,32'h28,32'hB),
                mk_exp(1,0,1,0, 32'h24, 32'hA,        0,32'hDEADBEEF, 0,32'h0,        0)};
    vec[7]  = '{mk_in(1,1,32'h2C,32'hC, 1,1,32'h28,32'hB),
                mk_exp(0,1,1,0, 32'h28, 32'hB,        0,32'hDEADBEEF, 0,32'h0,        1)};
    vec[8]  = '{mk_in(1,1,32'h2C,32'hC, 1,0,32'h20,0),
                mk_exp(1,0,1,0, 32'h2C, 32'hC,        0,32'hDEADBEEF, 0,32'h0,        0)};
    vec[9]  = '{mk_in(0,0,0,0, 1,0,32'h20,0),
                mk_exp(0,1,0,1, 32'h20, 32'h0,        0,32'hDEADBEEF, 0,32'h0,        0)};
    vec[10] = '{mk_in(1,0,32'h24,0, 1,0,32'h28,0),
                mk_exp(1,0,0,1, 32'h24, 32'h0,        0,32'hDEADBEEF, 1,32'h12345678, 0)};
    vec[11] = '{mk_in(0,0,0,0, 1,0,32'h28,0),
                mk_exp(0,1,0,1, 32'h28, 32'h0,        1,32'hA,        0,32'h12345678, 0)};
    vec[12] = '{mk_in(0,0,0,0, 0,0,0,0),
                mk_exp(0,0,0,0, 32'h0,  32'h0,        0,32'hA,        1,32'hB,        0)};

    for (int g = 0; g < 3; g++) begin
      din[g] = '0;
      din[g].rst = 1'b1;
    end
    tick();
    tick();
    for (int g = 0; g < 3; g++) din[g].rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check_obs(g, '0, "reset_state");
      check_val($sformatf("reset_stall_cnt%0d", g), stall_cnt[g], 32'h0);
    end
    tick();

    // RD_LAT=3 instance: both masters write every cycle; grants alternate starting with M0.
    k0 = 0;
    k1 = 0;
    for (int c = 0; c <= 10; c++) begin
      din[2] = mk_in(1, 1, 32'h40, 32'hA000 + k0, c < 10, 1, 32'h44, 32'h1000 + k1);
      @(negedge clk);
      e0 = (c == 10) || (c % 2 == 0);
      e1 = (c < 10) && (c % 2 == 1);
      check_val($sformatf("rr_cycle%0d", c), 32'({m0_gnt[2], m1_gnt[2], core_stall[2]}), 32'({e0, e1, e1}));
      if (c == 10) check_val("rr_stall_cnt", stall_cnt[2], 32'(5 * CNT_EN));
      if (m0_gnt[2]) k0++;
      if (m1_gnt[2]) k1++;
      tick();
    end

    // RD_LAT=3: M1 read at t, M0 read request from t+1 waits until the read completes.
    din[2] = mk_in(0,0,0,0, 1,0,32'h44,0);
    @(negedge clk);
    check_obs(2, mk_exp(0,1,0,1, 32'h44,0, 0,0, 0,0, 0), "lat3_t");
    tick();
    din[2] = mk_in(1,0,32'h40,0, 0,0,0,0);
    @(negedge clk);
    check_obs(2, mk_exp(0,0,0,0, 0,0, 0,0, 0,0, 1), "lat3_t+1");
    tick();
    @(negedge clk);
    check_obs(2, mk_exp(0,0,0,0, 0,0, 0,0, 0,0, 1), "lat3_t+2");
    tick();
    @(negedge clk);
    check_obs(2, mk_exp(1,0,0,1, 32'h40,0, 0,0, 1,32'h1004, 0), "lat3_t+3");
    tick();
    din[2] = mk_in(0,0,0,0, 0,0,0,0);
    @(negedge clk);
    check_obs(2, mk_exp(0,0,0,0, 0,0, 0,0, 0,32'h1004, 0), "lat3_t+4");
    tick();
    @(negedge clk);
    check_obs(2, mk_exp(0,0,0,0, 0,0, 0,0, 0,32'h1004, 0), "lat3_t+5");
    tick();
    @(negedge clk);
    check_obs(2, mk_exp(0,0,0,0, 0,0, 1,32'hA005, 0,32'h1004, 0), "lat3_t+6");
    tick();

    // RD_LAT=1 instance: vector table.
    for (int i = 0; i < 13; i++) begin
      din[0] = vec[i].in;
      @(negedge clk);
      check_obs(0, vec[i].exp, $sformatf("vec%0d", i));
      tick();
    end
    @(negedge clk);
    check_val("vec_stall_cnt", stall_cnt[0], 32'(CNT_EN));
    tick();

    // RD_LAT=2 instance: reset during a read drops it and restores the M0-first tie-break.
    din[1] = mk_in(1,0,32'h10,0, 0,0,0,0);
    @(negedge clk);
    check_obs(1, mk_exp(1,0,0,1, 32'h10,0, 0,0, 0,0, 0), "rst_read_t");
    tick();
    din[1] = '0;
    din[1].rst = 1'b1;
    @(negedge clk);
    check_obs(1, '0, "rst_t+1");
    check_val("rst_t+1_stall_cnt", stall_cnt[1], 32'h0);
    tick();
    din[1] = mk_in(1,1,32'h50,32'h5, 1,1,32'h54,32'h6);
    @(negedge clk);
    check_obs(1, mk_exp(1,0,1,0, 32'h50,32'h5, 0,0, 0,0, 0), "rst_t+2");
    tick();
    din[1] = mk_in(0,0,0,0, 1,1,32'h54,32'h6);
    @(negedge clk);
    check_obs(1, mk_exp(0,1,1,0, 32'h54,32'h6, 0,0, 0,0, 0), "rst_t+3");
    tick();
    din[1] = mk_in(0,0,0,0, 0,0,0,0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
